// File: rtl/fdown_game_if.sv
// Signal bundle between the fall-down game sequencer and the rest of the game.
// The controller takes the slave view; the board/datapath side takes the master view.
interface fdown_game_if;
  logic        btnS;
  logic        frame;
  logic        dead;
  logic [19:0] score;
  logic        run;
  logic        clr;
  logic [9:0]  floor_speed;
  logic [19:0] highest;
  logic [1:0]  state;
  logic        blink;

  modport master (
    output btnS, frame, dead, score,
    input  run, clr, floor_speed, highest, state, blink
  );

  modport slave (
    input  btnS, frame, dead, score,
    output run, clr, floor_speed, highest, state, blink
  );
endinterface

// File: rtl/fdown_game_ctrl.sv
// Fall-down game sequencer: button debounce, game FSM, floor speed schedule,
// high score tracking and display blink.
//
//   state | meaning
//   IDLE  | waiting for start press, datapath stopped
//   PLAY  | game running, datapath enabled
//   PAUSE | game frozen by press, display blinks
//   OVER  | ball reached top, display blinks until press
module fdown_game_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 6,
  parameter int LEVEL_FRAMES = 600,
  parameter int BLINK_DIV    = 100
) (
  input  logic        segclk,
  input  logic        rst,
  fdown_game_if.slave gif
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [9:0] LVL_LAST = 10'(LEVEL_FRAMES - 1);
  localparam logic [9:0] SPD_INIT = 10'(SPEED_INIT);
  localparam logic [9:0] SPD_MAX  = 10'(SPEED_MAX);
  localparam logic [7:0] BLK_LAST = 8'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        clr_q, clr_d;
  logic [1:0]  btn_sync, frame_sync, dead_sync;
  logic        frame_q, frame_tick;
  logic        deb_lvl, deb_q, press;
  logic [3:0]  deb_cnt;
  logic [9:0]  frame_cnt, speed_q;
  logic [19:0] highest_q;
  logic [7:0]  blink_cnt;
  logic        blink_q;
  logic        dead_s;

  assign dead_s = dead_sync[1];

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      btn_sync   <= '0;
      frame_sync <= '0;
      dead_sync  <= '0;
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      btn_sync   <= {btn_sync[0], gif.btnS};
      frame_sync <= {frame_sync[0], gif.frame};
      dead_sync  <= {dead_sync[0], gif.dead};
      frame_q    <= frame_sync[1];
      frame_tick <= frame_sync[1] & ~frame_q;
    end
  end

  // The counter measures how long the synced button has disagreed with the accepted level.
  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
      deb_q   <= 1'b0;
      press   <= 1'b0;
    end else begin
      if (btn_sync[1] == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        deb_lvl <= btn_sync[1];
      end else begin
        deb_cnt <= deb_cnt + 4'd1;
      end
      deb_q <= deb_lvl;
      press <= deb_lvl & ~deb_q;
    end
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // A death in the same cycle as a press ends the game; the press is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = PLAY;
          clr_d   = 1'b1;
        end
      end
      PLAY: begin
        if (dead_s)     state_d = OVER;
        else if (press) state_d = PAUSE;
      end
      PAUSE: begin
        if (press) state_d = PLAY;
      end
      OVER: begin
        if (press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      speed_q   <= SPD_INIT;
    end else if (clr_q) begin
      frame_cnt <= '0;
      speed_q   <= SPD_INIT;
    end else if (frame_tick && state_q == PLAY) begin
      if (frame_cnt == LVL_LAST) begin
        frame_cnt <= '0;
        if (speed_q < SPD_MAX) speed_q <= speed_q + 10'd1;
      end else begin
        frame_cnt <= frame_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      highest_q <= '0;
    end else if (state_q == PLAY && dead_s && gif.score > highest_q) begin
      highest_q <= gif.score;
    end
  end

  // Blink restarts whenever the state changes so each PAUSE/OVER visit starts lit.
  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if ((state_q == PAUSE || state_q == OVER) && state_d == state_q) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end else begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end
  end

  assign gif.run         = (state_q == PLAY);
  assign gif.clr         = clr_q;
  assign gif.floor_speed = speed_q;
  assign gif.highest     = highest_q;
  assign gif.state       = state_q;
  assign gif.blink       = blink_q;

endmodule

// File: tb/tb_fdown_game_ctrl.sv
// Bench for fdown_game_ctrl: directed game scenarios plus random button/frame/dead
// activity, checked every cycle against an event-level model of the game rules.
module tb_fdown_game_ctrl;
  localparam int DEB = 4, SP_INIT = 2, SP_MAX = 6, LF = 4, BD = 100;

  logic segclk = 1'b0;
  logic rst    = 1'b1;

  fdown_game_if gif();

  fdown_game_ctrl #(
    .DEB_CYCLES(DEB), .SPEED_INIT(SP_INIT), .SPEED_MAX(SP_MAX),
    .LEVEL_FRAMES(LF), .BLINK_DIV(BD)
  ) dut (
    .segclk(segclk),
    .rst   (rst),
    .gif   (gif)
  );

  always #5 segclk = ~segclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge segclk);
  endtask

  // Model: inputs are seen through sample histories, the button is accepted after
  // DEB consecutive disagreeing samples, speed is derived from ticks since clear,
  // blink from cycles elapsed since entering PAUSE/OVER.
  logic [3:0]  bh, dh, fh;
  int          mis, rise_edge, edge_n, ticks, entry;
  bit          m_deb, m_clr, m_blink;
  logic [1:0]  m_state;
  logic [19:0] m_high;
  int          m_speed;

  always @(posedge segclk or posedge rst) begin : model
    bit b_s, d_s, tk, prs, ndeb, nclr;
    int nmis, nrise, nticks, nentry, e, spd;
    logic [1:0]  nst;
    logic [19:0] nhigh;
    if (rst) begin
      bh <= '0; dh <= '0; fh <= '0;
      mis <= 0; m_deb <= 1'b0; rise_edge <= -10; edge_n <= 0;
      ticks <= 0; entry <= 0;
      m_state <= 2'd0; m_clr <= 1'b0; m_blink <= 1'b1; m_high <= '0; m_speed <= SP_INIT;
    end else begin
      e   = edge_n + 1;
      b_s = bh[1];
      d_s = dh[1];
      tk  = fh[2] & ~fh[3];
      prs = (e == rise_edge + 2);
      ndeb = m_deb; nmis = mis; nrise = rise_edge;
      if (b_s != m_deb) begin
        nmis = mis + 1;
        if (nmis == DEB) begin
          ndeb = b_s;
          nmis = 0;
          if (b_s) nrise = e;
        end
      end else begin
        nmis = 0;
      end
      nst = m_state; nclr = 1'b0; nhigh = m_high;
      case (m_state)
        2'd0: if (prs) begin nst = 2'd1; nclr = 1'b1; end
        2'd1: begin
          if (d_s) begin
            nst = 2'd3;
            if (gif.score > m_high) nhigh = gif.score;
          end else if (prs) begin
            nst = 2'd2;
          end
        end
        2'd2: if (prs) nst = 2'd1;
        default: if (prs) nst = 2'd0;
      endcase
      nticks = m_clr ? 0 : ((tk && m_state == 2'd1) ? ticks + 1 : ticks);
      spd = SP_INIT + nticks / LF;
      if (spd > SP_MAX) spd = SP_MAX;
      nentry = entry;
      if (nst != m_state && (nst == 2'd2 || nst == 2'd3)) nentry = e;
      m_deb <= ndeb; mis <= nmis; rise_edge <= nrise;
      m_state <= nst; m_clr <= nclr; m_high <= nhigh;
      ticks <= nticks; m_speed <= spd; entry <= nentry;
      m_blink <= (nst == 2'd2 || nst == 2'd3) ? (((e - nentry) / BD) % 2 == 0) : 1'b1;
      bh <= {bh[2:0], gif.btnS};
      dh <= {dh[2:0], gif.dead};
      fh <= {fh[2:0], gif.frame};
      edge_n <= e;
    end
  end

  always @(negedge segclk) begin
    if (!rst) begin
      chk("state",       gif.state,       m_state);
      chk("run",         gif.run,         m_state == 2'd1);
      chk("clr",         gif.clr,         m_clr);
      chk("floor_speed", gif.floor_speed, m_speed);
      chk("highest",     gif.highest,     m_high);
      chk("blink",       gif.blink,       m_blink);
    end
  end

  int clr_cnt = 0;
  always @(negedge segclk) if (!rst && gif.clr) clr_cnt++;

  task automatic press_clean();
    gif.btnS = 1'b1;
    cyc(10);
    gif.btnS = 1'b0;
    cyc(10);
  endtask

  task automatic send_frames(input int k);
    for (int i = 0; i < k; i++) begin
      gif.frame = 1'b1;
      cyc(3);
      gif.frame = 1'b0;
      cyc(3);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, gif.state, 0);
    chk({tag, "_run"},   gif.run,   0);
    chk({tag, "_clr"},   gif.clr,   0);
    chk({tag, "_speed"}, gif.floor_speed, SP_INIT);
    chk({tag, "_high"},  gif.highest, 0);
    chk({tag, "_blink"}, gif.blink, 1);
  endtask

  int glitch[6] = '{1, 2, 3, 1, 2, 2};

  initial begin
    int c0, toggles, bcnt, fcnt, dcnt;
    logic prev_blink;
    gif.btnS = 1'b0; gif.frame = 1'b0; gif.dead = 1'b0; gif.score = '0;
    cyc(3);
    chk_reset_vals("rst_init");
    rst = 1'b0;
    cyc(2);

    // start a game
    c0 = clr_cnt;
    press_clean();
    chk("start_state", gif.state, 1);
    chk("start_run", gif.run, 1);
    chk("start_clr_pulses", clr_cnt - c0, 1);
    chk("start_speed", gif.floor_speed, 2);
    chk("model_pin_start", m_state, 1);

    // chatter shorter than the debounce window, then a real press
    for (int i = 0; i < 6; i++) begin
      gif.btnS = (i % 2 == 0);
      cyc(glitch[i]);
    end
    chk("chatter_no_press", gif.state, 1);
    press_clean();
    chk("pause_state", gif.state, 2);
    chk("pause_run", gif.run, 0);
    toggles = 0;
    prev_blink = gif.blink;
    for (int i = 0; i < 250; i++) begin
      gif.frame = ((i / 3) % 2 == 0);
      cyc(1);
      if (gif.blink != prev_blink) toggles++;
      prev_blink = gif.blink;
    end
    gif.frame = 1'b0;
    chk("pause_blink_toggles", toggles, 2);
    chk("pause_speed_frozen", gif.floor_speed, 2);

    // resume and run the speed schedule to saturation
    press_clean();
    chk("resume_state", gif.state, 1);
    send_frames(4);
    chk("speed_step1", gif.floor_speed, 3);
    send_frames(26);
    chk("speed_sat", gif.floor_speed, 6);
    chk("model_pin_speed", m_speed, 6);

    // game over with a new high score, dead latency of three cycles
    gif.score = 20'd1234;
    gif.dead = 1'b1;
    cyc(2);
    chk("dead_lat_still_play", gif.state, 1);
    cyc(1);
    chk("over_state", gif.state, 3);
    chk("over_run", gif.run, 0);
    chk("over_high", gif.highest, 1234);
    gif.dead = 1'b0;
    cyc(5);
    press_clean();
    chk("over_to_idle", gif.state, 0);
    c0 = clr_cnt;
    press_clean();
    chk("restart_clr", clr_cnt - c0, 1);
    chk("restart_speed", gif.floor_speed, 2);
    chk("restart_high", gif.highest, 1234);
    gif.score = 20'd500;
    gif.dead = 1'b1;
    cyc(3);
    chk("low_score_over", gif.state, 3);
    chk("low_score_high", gif.highest, 1234);
    chk("model_pin_high", m_high, 1234);
    gif.dead = 1'b0;
    cyc(5);

    // dead and press reach the FSM in the same cycle
    press_clean();
    press_clean();
    chk("sim_pre_play", gif.state, 1);
    gif.btnS = 1'b1;
    cyc(5);
    gif.dead = 1'b1;
    cyc(3);
    chk("sim_dead_wins", gif.state, 3);
    gif.dead = 1'b0;
    cyc(2);
    gif.btnS = 1'b0;
    cyc(10);
    chk("sim_press_dropped", gif.state, 3);

    // reset mid-game while paused at speed 5
    press_clean();
    press_clean();
    send_frames(12);
    chk("pre_rst_speed", gif.floor_speed, 5);
    press_clean();
    chk("pre_rst_pause", gif.state, 2);
    #3 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    chk("model_pin_rst", m_speed, SP_INIT);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // random activity
    bcnt = 0; fcnt = 0; dcnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge segclk);
      if (bcnt == 0) begin
        gif.btnS = ~gif.btnS;
        bcnt = $urandom_range(1, 14);
      end else bcnt--;
      if (fcnt == 0) begin
        gif.frame = ~gif.frame;
        fcnt = $urandom_range(1, 7);
      end else fcnt--;
      if (dcnt == 0) begin
        gif.dead = ($urandom_range(0, 9) == 0);
        dcnt = $urandom_range(2, 20);
      end else dcnt--;
      if (m_state == 2'd1 && $urandom_range(0, 3) == 0) gif.score = 20'($urandom);
    end
    gif.btnS = 1'b0; gif.frame = 1'b0; gif.dead = 1'b0;
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
